// File: rtl/btn_pkg.sv
// Shared types and constants for the button debouncer / reset generator.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_HELD,
    ST_REL_WAIT
  } btn_state_e;

  // Dividing a clock frequency in Hz by this gives cycles per millisecond.
  localparam int unsigned MS_DIVISOR = 1000;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / MS_DIVISOR) * ms;
  endfunction

  // Counters only need to reach threshold-1; the extra bit keeps threshold=1 legal.
  function automatic int unsigned cnt_width(input int unsigned threshold);
    return $clog2(threshold) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, press/release/long pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned LONG_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic held_o,
  output logic idle_o
);

  localparam int unsigned DW = cnt_width(DEB_CYCLES);
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  // btn_long is visible in the cycle the hold counter is about to reach LONG_CYCLES-1.
  localparam logic [HW-1:0] LONG_FIRE = (LONG_CYCLES >= 2) ? HW'(LONG_CYCLES - 2) : '0;

  logic [1:0]    sync_q;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          was_held_q, was_held_d;
  logic          sample;
  logic          press, release_p, long_p;

  assign sample = ~sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchronizer resets to "released" (btn_n high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      deb_q      <= '0;
      hold_q     <= '0;
      was_held_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_n_i};
      state_q    <= state_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      was_held_q <= was_held_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    deb_d      = deb_q;
    hold_d     = hold_q;
    was_held_d = was_held_q;
    press      = 1'b0;
    release_p  = 1'b0;
    long_p     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample) begin
          state_d = ST_PRESS_WAIT;
          deb_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sample) begin
          state_d = ST_IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d    = ST_PRESSED;
          press      = 1'b1;
          hold_d     = '0;
          was_held_d = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      ST_PRESSED: begin
        hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HW'(1);
        if (!sample) begin
          state_d = ST_REL_WAIT;
          deb_d   = '0;
        end else if (hold_q >= LONG_FIRE) begin
          state_d    = ST_HELD;
          long_p     = 1'b1;
          was_held_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!sample) begin
          state_d = ST_REL_WAIT;
          deb_d   = '0;
        end
      end
      ST_REL_WAIT: begin
        // A bounce back resumes where the press left off; the hold count is frozen here.
        if (sample) begin
          state_d = was_held_q ? ST_HELD : ST_PRESSED;
        end else if (deb_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          release_p = 1'b1;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign press_o   = press;
  assign release_o = release_p;
  assign long_o    = long_p;
  assign level_o   = press || (state_q == ST_PRESSED) || (state_q == ST_HELD)
                     || (state_q == ST_REL_WAIT);
  assign held_o    = (state_q == ST_HELD);
  assign idle_o    = (state_q == ST_IDLE);

endmodule

// File: rtl/btn_debounce_rstgen.sv
// Two debounced buttons plus a system reset generator with a dual-long-press soft reset.
module btn_debounce_rstgen
  import btn_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 27_000_000,
  parameter int unsigned DEB_CYCLES  = ms_to_cycles(CLK_FREQ, 10),
  parameter int unsigned LONG_CYCLES = CLK_FREQ,
  parameter int unsigned POR_CYCLES  = ms_to_cycles(CLK_FREQ, 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn_n,
  output logic       sys_rst_n,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release,
  output logic [1:0] btn_long
);

  localparam int unsigned PW = cnt_width(POR_CYCLES);
  localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);

  logic [1:0]    ch_held, ch_idle;
  logic [PW-1:0] por_cnt_q, por_cnt_d;
  logic          rst_out_q, rst_out_d;
  logic          arm_q, arm_d;
  logic          soft_fire;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_n_i  (btn_n[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g]),
      .long_o   (btn_long[g]),
      .held_o   (ch_held[g]),
      .idle_o   (ch_idle[g])
    );
  end

  // Fires in the cycle the second channel's btn_long pulses (or both together).
  assign soft_fire = arm_q && (&(ch_held | btn_long));

  always_comb begin
    por_cnt_d = por_cnt_q;
    rst_out_d = rst_out_q;
    arm_d     = arm_q;
    if (soft_fire) begin
      rst_out_d = 1'b0;
      por_cnt_d = '0;
      arm_d     = 1'b0;
    end else begin
      if (&ch_idle) arm_d = 1'b1;
      if (!rst_out_q) begin
        if (por_cnt_q == POR_LAST) rst_out_d = 1'b1;
        else                       por_cnt_d = por_cnt_q + PW'(1);
      end
    end
  end

  // sys_rst_n drops asynchronously with rst_n and is only ever released by a clk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      por_cnt_q <= '0;
      rst_out_q <= 1'b0;
      arm_q     <= 1'b1;
    end else begin
      por_cnt_q <= por_cnt_d;
      rst_out_q <= rst_out_d;
      arm_q     <= arm_d;
    end
  end

  assign sys_rst_n = rst_out_q;

endmodule

// File: tb/tb_btn_debounce_rstgen.sv
// Directed bench for btn_debounce_rstgen with DEB=4, LONG=20, POR=8.
module tb_btn_debounce_rstgen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn_n = 2'b11;
  logic       sys_rst_n;
  logic [1:0] btn_level, btn_press, btn_release, btn_long;

  always #5 clk = ~clk;

  btn_debounce_rstgen #(
    .CLK_FREQ   (27_000_000),
    .DEB_CYCLES (4),
    .LONG_CYCLES(20),
    .POR_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .sys_rst_n  (sys_rst_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Event recorder: samples outputs 2 time units after each rising edge.
  int   cyc = 0;
  int   press_cnt[2], rel_cnt[2], long_cnt[2], lvl_cnt[2];
  int   press_cyc[2], rel_cyc[2], long_cyc[2];
  int   fall_cnt = 0, rise_cnt = 0, fall_cyc = -1, rise_cyc = -1;
  int   excl_err = 0;
  logic sys_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (btn_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (btn_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
      if (btn_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
      if (btn_level[i])   lvl_cnt[i]++;
      if (int'(btn_press[i]) + int'(btn_release[i]) + int'(btn_long[i]) > 1) excl_err++;
    end
    if (sys_rst_n && !sys_prev) begin rise_cnt++; rise_cyc = cyc; end
    if (!sys_rst_n && sys_prev) begin fall_cnt++; fall_cyc = cyc; end
    sys_prev = sys_rst_n;
  end

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0; lvl_cnt[i] = 0;
      press_cyc[i] = -1; rel_cyc[i] = -1; long_cyc[i] = -1;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c0, c1, c2, c3, f0;

  initial begin
    clear_counts();

    // Reset state
    wait_cyc(3);
    check("rst_sys_rst_n", int'(sys_rst_n), 0);
    check("rst_btn_outputs", int'({btn_level, btn_press, btn_release, btn_long}), 0);

    // Power-on reset hold
    rst_n = 1'b1;
    c0 = cyc;
    wait_cyc(12);
    check("por_rise_cycle", rise_cyc, c0 + 8);
    check("por_rise_count", rise_cnt, 1);
    check("por_no_pulses", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1]
                           + long_cnt[0] + long_cnt[1] + lvl_cnt[0] + lvl_cnt[1], 0);

    // Clean 30-cycle press on channel 0
    clear_counts();
    c1 = cyc;
    btn_n[0] = 1'b0;
    wait_cyc(30);
    c2 = cyc;
    btn_n[0] = 1'b1;
    wait_cyc(12);
    check("ch0_press_cycle", press_cyc[0], c1 + 6);
    check("ch0_press_count", press_cnt[0], 1);
    check("ch0_long_cycle", long_cyc[0], c1 + 25);
    check("ch0_long_count", long_cnt[0], 1);
    check("ch0_release_cycle", rel_cyc[0], c2 + 6);
    check("ch0_release_count", rel_cnt[0], 1);
    check("ch0_level_cycles", lvl_cnt[0], 31);
    check("ch1_quiet", press_cnt[1] + lvl_cnt[1], 0);
    check("no_soft_reset_single", fall_cnt, 0);

    // Bouncing channel 1 never settles
    clear_counts();
    repeat (5) begin
      btn_n[1] = 1'b0;
      wait_cyc(3);
      btn_n[1] = 1'b1;
      wait_cyc(1);
    end
    wait_cyc(10);
    check("bounce_no_press", press_cnt[1], 0);
    check("bounce_no_other", rel_cnt[1] + long_cnt[1], 0);
    check("bounce_level_low", lvl_cnt[1], 0);

    // Held press with a 2-cycle release bounce
    clear_counts();
    c1 = cyc;
    btn_n[0] = 1'b0;
    wait_cyc(10);
    btn_n[0] = 1'b1;
    wait_cyc(2);
    btn_n[0] = 1'b0;
    wait_cyc(28);
    check("glitch_no_release", rel_cnt[0], 0);
    btn_n[0] = 1'b1;
    wait_cyc(12);
    check("glitch_press_count", press_cnt[0], 1);
    check("glitch_long_count", long_cnt[0], 1);
    check("glitch_long_cycle", long_cyc[0], c1 + 27);
    check("glitch_release_cycle", rel_cyc[0], c1 + 46);
    check("glitch_release_count", rel_cnt[0], 1);

    // Dual long press soft reset, no repeat, then re-armed
    clear_counts();
    f0 = fall_cnt;
    c1 = cyc;
    btn_n = 2'b00;
    wait_cyc(40);
    check("soft_fall_count", fall_cnt - f0, 1);
    check("soft_fall_cycle", fall_cyc, c1 + 26);
    check("soft_rise_cycle", rise_cyc, c1 + 34);
    check("soft_long_both", long_cnt[0] * 10 + long_cnt[1], 11);
    check("soft_keeps_level", lvl_cnt[0], 35);
    wait_cyc(20);
    check("soft_no_repeat", fall_cnt - f0, 1);
    btn_n = 2'b11;
    wait_cyc(12);
    c2 = cyc;
    btn_n = 2'b00;
    wait_cyc(40);
    check("soft_rearm_count", fall_cnt - f0, 2);
    check("soft_rearm_cycle", fall_cyc, c2 + 26);
    btn_n = 2'b11;
    wait_cyc(12);

    // rst_n asserted mid-press
    clear_counts();
    c1 = cyc;
    btn_n[0] = 1'b0;
    wait_cyc(10);
    check("midrst_level_before", int'(btn_level[0]), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_level_cleared", int'(btn_level[0]), 0);
    check("midrst_sys_rst_n", int'(sys_rst_n), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    c3 = cyc;
    wait_cyc(10);
    check("midrst_repress_cycle", press_cyc[0], c3 + 6);
    check("midrst_press_count", press_cnt[0], 2);
    check("midrst_no_release", rel_cnt[0], 0);
    check("midrst_sys_released", int'(sys_rst_n), 1);
    btn_n[0] = 1'b1;
    wait_cyc(12);
    check("midrst_final_release", rel_cnt[0], 1);

    check("pulses_exclusive", excl_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce_rstgen.md
BTN_DEBOUNCE_RSTGEN -- requirements
Module: btn_debounce_rstgen

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
  CLK_FREQ  27_000_000  clock frequency in Hz
  DEB_CYCLES  CLK_FREQ/100  debounce stable time (10 ms)
  LONG_CYCLES  CLK_FREQ  long-press threshold (1 s)
  POR_CYCLES  CLK_FREQ/1000  system reset hold time (1 ms)
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  input  1  single system clock
  rst_n  input  1  asynchronous, active-low reset
  btn_n  input  2  raw active-low push buttons, asynchronous to clk
  sys_rst_n  output  1  generated active-low system reset for downstream blocks (e.g. LED blinker)
  btn_level  output  2  debounced pressed level, 1 = pressed
  btn_press  output  2  one-cycle pulse on debounced press
  btn_release  output  2  one-cycle pulse on debounced release
  btn_long  output  2  one-cycle pulse when a press reaches LONG_CYCLES
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Each btn_n bit SHALL pass through a 2-flop synchronizer; its inverted output (pressed = 1) is the per-channel sample.
REQ-005 Each channel SHALL run an independent FSM with these states: IDLE, PRESS_WAIT, PRESSED, HELD, REL_WAIT.
REQ-006 In IDLE, sample = 1 SHALL move to PRESS_WAIT and clear the debounce counter.
REQ-007 In PRESS_WAIT, the counter SHALL increment while sample = 1.
REQ-008 In PRESS_WAIT, sample = 0 SHALL return to IDLE with no pulse.
REQ-009 In PRESS_WAIT, when the counter reaches DEB_CYCLES-1 with sample = 1, the FSM SHALL enter PRESSED, set btn_level, pulse btn_press, and clear the hold counter.
REQ-010 In PRESSED, the hold counter SHALL increment every cycle.
REQ-011 In PRESSED, when the hold counter reaches LONG_CYCLES-1, the FSM SHALL pulse btn_long once and enter HELD; the counter SHALL saturate and not wrap.
REQ-012 In PRESSED or HELD, sample = 0 SHALL move to REL_WAIT and clear the debounce counter.
REQ-013 In REL_WAIT, sample = 1 SHALL return to the prior state (PRESSED or HELD) without resetting the hold counter.
REQ-014 In REL_WAIT, DEB_CYCLES consecutive 0 samples SHALL move to IDLE, clear btn_level, and pulse btn_release.
REQ-015 Latency: btn_press SHALL assert exactly 2 + DEB_CYCLES cycles after a clean btn_n falling edge; btn_release SHALL follow the same rule after a clean rising edge.
REQ-016 btn_press, btn_release and btn_long SHALL each be exactly one cycle wide and never assert in the same cycle on one channel.
REQ-017 sys_rst_n SHALL be held low for POR_CYCLES cycles after rst_n deasserts, then go high on a clk edge.
REQ-018 A soft reset SHALL occur when both channels are simultaneously in HELD, entered on the cycle the second btn_long fires: sys_rst_n SHALL go low for POR_CYCLES cycles, then release.
REQ-019 A further soft reset SHALL be re-armed only after both channels have returned to IDLE.
REQ-020 A soft reset SHALL NOT reset the channel FSMs.
REQ-021 Counter widths SHALL be $clog2 of their threshold plus 1; thresholds of 1 SHALL be legal.

Reset
REQ-022 While rst_n = 0, all of the following SHALL hold: sys_rst_n = 0, all btn_* outputs = 0, FSMs = IDLE, counters = 0, synchronizer flops = released, soft-reset arm = 1.
REQ-023 rst_n asserted mid-press SHALL abort immediately with no release pulse; after reset, a still-held button SHALL be debounced as a new press.
REQ-024 sys_rst_n SHALL assert asynchronously with rst_n and deassert synchronously to clk.

Structure
REQ-025 The FSM state encoding and the ms-to-cycles conversion constant (CLK_FREQ/1000) SHALL live in a shared package, btn_pkg.
REQ-026 The synchronizer, FSM and counters SHALL form one sub-module, btn_channel, instantiated twice.
REQ-027 The top level SHALL hold only the reset generator and the soft-reset combine logic.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, POR_CYCLES=8)
REQ-028 Release rst_n -> sys_rst_n rises exactly 8 cycles later; all btn_* outputs stay 0.
REQ-029 Hold btn_n[0] low for 30 cycles, then release -> btn_press[0] at cycle 6; btn_long[0] at cycle 25; btn_release[0] 6 cycles after release; btn_level[0] high between press and release.
REQ-030 Bounce btn_n[1] low for 3 cycles, high for 1, repeated 5 times -> no pulses, btn_level[1] stays 0.
REQ-031 During a held press, bounce high for 2 cycles -> no release pulse, no second btn_press; btn_long still fires once.
REQ-032 Hold both buttons for 30 cycles -> sys_rst_n low for 8 cycles once; holding longer gives no repeat; after release and a new dual hold, a second soft reset occurs.
REQ-033 Assert rst_n at cycle 10 of a held press -> outputs clear immediately; on deassert with button still held, btn_press fires again after 6 cycles.
